// File: rtl/i2s_tx_serializer.sv
// I2S transmitter: pops 16-bit PCM words from the audio FIFO read port and serialises L/R slots.
// Optional `I2S_TX_HOLD_LAST_EN: an underrun slot repeats the last good word of that channel.
module i2s_tx_serializer #(
    parameter int DATA_WIDTH = 16,
    parameter int SLOT_WIDTH = 16,
    parameter int BCLK_DIV   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_rd_vld,
    output logic                  fifo_rd_en,
    output logic                  i2s_bclk,
    output logic                  i2s_lrck,
    output logic                  i2s_sdata,
    output logic                  underrun,
    output logic                  busy
);

    localparam int DIV_W = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
    localparam int BIT_W = $clog2(2 * SLOT_WIDTH);
    localparam int PAD   = SLOT_WIDTH - DATA_WIDTH;

    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(BCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF    = DIV_W'(BCLK_DIV / 2);
    localparam logic [BIT_W-1:0] LEFT_LAST   = BIT_W'(SLOT_WIDTH - 1);
    localparam logic [BIT_W-1:0] RIGHT_FIRST = BIT_W'(SLOT_WIDTH);
    localparam logic [BIT_W-1:0] RIGHT_LAST  = BIT_W'(2 * SLOT_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    // Bit SLOT_WIDTH is the next bit to drive; it carries the previous word's LSB across slots.
    logic [SLOT_WIDTH:0]  sr_q, sr_d;
    logic                 bclk_q, bclk_d;
    logic                 lrck_q, lrck_d;
    logic                 sdata_q, sdata_d;
    logic                 busy_q, busy_d;

`ifdef I2S_TX_HOLD_LAST_EN
    logic [SLOT_WIDTH-1:0] hold_l_q, hold_l_d;
    logic [SLOT_WIDTH-1:0] hold_r_q, hold_r_d;
`endif

    logic                  div_wrap;
    logic                  slot_end;
    logic                  load_pt;
    logic                  to_right;
    logic                  want_word;
    logic                  run_pop;
    logic                  arm_pop;
    logic [SLOT_WIDTH-1:0] rd_word;
    logic [SLOT_WIDTH-1:0] load_word;

    always_comb begin
        div_wrap  = (div_cnt_q == DIV_LAST);
        slot_end  = (bit_cnt_q == LEFT_LAST) || (bit_cnt_q == RIGHT_LAST);
        load_pt   = (state_q == RUN) && div_wrap && slot_end;
        to_right  = (bit_cnt_q == LEFT_LAST);
        // A right slot is always fetched so a started frame completes even after enable drops.
        want_word = enable || to_right;
        run_pop   = load_pt && want_word && fifo_rd_vld;
        arm_pop   = (state_q == ARM) && fifo_rd_vld;
        rd_word   = SLOT_WIDTH'(fifo_rd_data) << PAD;
`ifdef I2S_TX_HOLD_LAST_EN
        load_word = fifo_rd_vld ? rd_word : (to_right ? hold_r_q : hold_l_q);
`else
        load_word = fifo_rd_vld ? rd_word : '0;
`endif
        fifo_rd_en = !rst && (run_pop || arm_pop);
        underrun   = !rst && load_pt && want_word && !fifo_rd_vld;
    end

    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        sr_d      = sr_q;
        sdata_d   = sdata_q;
`ifdef I2S_TX_HOLD_LAST_EN
        hold_l_d  = hold_l_q;
        hold_r_d  = hold_r_q;
`endif
        case (state_q)
            IDLE: begin
                div_cnt_d = '0;
                bit_cnt_d = '0;
                sr_d      = '0;
                sdata_d   = 1'b0;
                if (enable) state_d = ARM;
            end
            ARM: begin
                sdata_d = 1'b0;
                if (fifo_rd_vld) begin
                    state_d   = RUN;
                    div_cnt_d = '0;
                    bit_cnt_d = '0;
                    sr_d      = {rd_word, 1'b0};
`ifdef I2S_TX_HOLD_LAST_EN
                    hold_l_d  = rd_word;
`endif
                end else if (!enable) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                div_cnt_d = div_wrap ? '0 : div_cnt_q + 1'b1;
                if (div_wrap) begin
                    sdata_d   = sr_q[SLOT_WIDTH];
                    bit_cnt_d = (bit_cnt_q == RIGHT_LAST) ? '0 : bit_cnt_q + 1'b1;
                    sr_d      = {sr_q[SLOT_WIDTH-1:0], 1'b0};
                    if (load_pt) begin
                        if (want_word) begin
                            sr_d = {load_word, 1'b0};
                        end else begin
                            state_d   = DRAIN;
                            bit_cnt_d = '0;
                            sr_d      = '0;
                        end
                    end
                end
            end
            DRAIN: begin
                div_cnt_d = div_cnt_q + 1'b1;
                if (div_wrap) begin
                    state_d   = IDLE;
                    div_cnt_d = '0;
                    sdata_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef I2S_TX_HOLD_LAST_EN
        if (run_pop) begin
            if (to_right) hold_r_d = rd_word;
            else          hold_l_d = rd_word;
        end
`endif
        bclk_d = ((state_d == RUN) || (state_d == DRAIN)) && (div_cnt_d >= DIV_HALF);
        lrck_d = (state_d == RUN) && (bit_cnt_d >= RIGHT_FIRST);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            sr_q      <= '0;
            bclk_q    <= 1'b0;
            lrck_q    <= 1'b0;
            sdata_q   <= 1'b0;
            busy_q    <= 1'b0;
`ifdef I2S_TX_HOLD_LAST_EN
            hold_l_q  <= '0;
            hold_r_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            sr_q      <= sr_d;
            bclk_q    <= bclk_d;
            lrck_q    <= lrck_d;
            sdata_q   <= sdata_d;
            busy_q    <= busy_d;
`ifdef I2S_TX_HOLD_LAST_EN
            hold_l_q  <= hold_l_d;
            hold_r_q  <= hold_r_d;
`endif
        end
    end

    assign i2s_bclk  = bclk_q;
    assign i2s_lrck  = lrck_q;
    assign i2s_sdata = sdata_q;
    assign busy      = busy_q;

endmodule
